// File: rtl/multiplexor_display_pkg.sv
// Shared definitions for the 4-digit multiplexed display: scan states,
// digit count and a one-hot helper for the anode enables.
package multiplexor_display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = 2;

    typedef enum logic {
        ST_ON    = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    function automatic logic [NUM_DIGITS-1:0] one_hot(input logic [IDX_W-1:0] idx);
        one_hot      = '0;
        one_hot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/contador_prescaler.sv
// Free-running prescaler: counts up from 0, flags when it reaches i_Limite,
// and restarts from 0 on i_Clear.
module contador_prescaler #(
    parameter int WIDTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Clear,
    input  logic [WIDTH-1:0] i_Limite,
    output logic             o_Fin
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign o_Fin = (cnt_q == i_Limite);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_Clear) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multiplexor_display.sv
// Time-multiplexed driver for four 7-segment digits with an anode-off guard
// interval, tear-free frame-aligned loading and optional leading-zero blanking.
module multiplexor_display
    import multiplexor_display_pkg::*;
#(
    parameter int CLK_DIV       = 50000,
    parameter int BLANK_CYCLES  = 16,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [15:0] i_Valor,
    input  logic        i_Cargar,
    input  logic        i_Blank_Ceros,
    output logic [3:0]  o_Bits,
    output logic [3:0]  o_Anodos,
    output logic        o_Ocupado
);

    localparam int MAX_CNT   = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W     = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam bit HAS_GUARD = (BLANK_CYCLES != 0);
    localparam logic [CNT_W-1:0] ON_LIM    = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(HAS_GUARD ? BLANK_CYCLES - 1 : 0);
    localparam logic [NUM_DIGITS-1:0] AN_RST = AN_ACTIVE_LOW ? 4'b1110 : 4'b0001;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [15:0]             shadow_q, shadow_d;
    logic [15:0]             disp_q, disp_d;
    logic                    busy_q, busy_d;
    logic [3:0]              bits_q, bits_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;

    logic                    presc_fin;
    logic [CNT_W-1:0]        presc_lim;
    logic                    advance;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   lit;
    logic [NUM_DIGITS-1:0]   act;

    assign presc_lim = (state_q == ST_ON) ? ON_LIM : BLANK_LIM;

    // Every terminal count is also a state transition, so it doubles as the clear.
    contador_prescaler #(
        .WIDTH (CNT_W)
    ) u_prescaler (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Clear  (presc_fin),
        .i_Limite (presc_lim),
        .o_Fin    (presc_fin)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        busy_d   = busy_q;
        advance  = 1'b0;

        if (presc_fin) begin
            if (state_q == ST_ON && HAS_GUARD) begin
                state_d = ST_BLANK;
            end else begin
                state_d = ST_ON;
                advance = 1'b1;
            end
        end

        if (advance) begin
            idx_d = idx_q + 1'b1;
        end
        wrap = advance && (idx_q == IDX_W'(NUM_DIGITS - 1));

        if (wrap && busy_q) begin
            disp_d = shadow_q;
            busy_d = 1'b0;
        end
        // A load on the wrap clock still wins: shadow refills and busy stays set.
        if (i_Cargar) begin
            shadow_d = i_Valor;
            busy_d   = 1'b1;
        end

        // Outputs are computed from next-state values so their flops line up
        // with the state flops without an extra cycle of lag.
        lit = '1;
        if (i_Blank_Ceros) begin
            for (int k = 1; k < NUM_DIGITS; k++) begin
                lit[k] = ((disp_d >> (4 * k)) != '0);
            end
        end
        act      = (state_d == ST_ON) ? (one_hot(idx_d) & lit) : '0;
        anodes_d = AN_ACTIVE_LOW ? ~act : act;
        bits_d   = disp_d[{idx_d, 2'b00} +: 4];
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= ST_ON;
            idx_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            busy_q   <= 1'b0;
            bits_q   <= 4'h0;
            anodes_q <= AN_RST;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            busy_q   <= busy_d;
            bits_q   <= bits_d;
            anodes_q <= anodes_d;
        end
    end

    assign o_Bits    = bits_q;
    assign o_Anodos  = anodes_q;
    assign o_Ocupado = busy_q;

endmodule

// File: tb/tb_multiplexor_display.sv
// Self-checking bench for multiplexor_display: a guarded build (CLK_DIV=4,
// BLANK_CYCLES=2) and a no-guard build (BLANK_CYCLES=0) share the stimulus.
module tb_multiplexor_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] valor;
    logic        cargar;
    logic        blank_ceros;
    logic [3:0]  bits, anodos;
    logic        ocupado;
    logic [3:0]  bits_ng, anodos_ng;
    logic        ocupado_ng;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    multiplexor_display #(
        .CLK_DIV       (4),
        .BLANK_CYCLES  (2),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Valor       (valor),
        .i_Cargar      (cargar),
        .i_Blank_Ceros (blank_ceros),
        .o_Bits        (bits),
        .o_Anodos      (anodos),
        .o_Ocupado     (ocupado)
    );

    multiplexor_display #(
        .CLK_DIV       (4),
        .BLANK_CYCLES  (0),
        .AN_ACTIVE_LOW (1'b1)
    ) dut_ng (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Valor       (valor),
        .i_Cargar      (cargar),
        .i_Blank_Ceros (blank_ceros),
        .o_Bits        (bits_ng),
        .o_Anodos      (anodos_ng),
        .o_Ocupado     (ocupado_ng)
    );

    typedef struct {
        string       name;
        logic [15:0] valor;
        logic        blank;
        logic [3:0]  lit;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    // Asynchronous reset: outputs must be at reset values before any clock edge.
    task automatic do_reset();
        cargar = 1'b0;
        rst    = 1'b1;
        #1;
        check("rst_anodos", 16'(anodos), 16'hE);
        check("rst_bits", 16'(bits), 16'h0);
        check("rst_ocupado", 16'(ocupado), 16'h0);
        check("rst_ng_anodos", 16'(anodos_ng), 16'hE);
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic load(input logic [15:0] v);
        valor  = v;
        cargar = 1'b1;
        tick();
        cargar = 1'b0;
    endtask

    // Scan position from elapsed clocks since reset release; per = clocks per digit.
    function automatic logic [3:0] model_an(input int n, input logic [3:0] lit,
                                            input int on_len, input int per);
        int p, d;
        p = n % (4 * per);
        d = p / per;
        if ((p % per) < on_len && lit[d]) return ~(4'b0001 << d);
        return 4'hF;
    endfunction

    function automatic logic [3:0] model_bits(input int n, input logic [15:0] v, input int per);
        int d;
        d = (n % (4 * per)) / per;
        return v[4*d +: 4];
    endfunction

    initial begin
        rst         = 1'b1;
        valor       = '0;
        cargar      = 1'b0;
        blank_ceros = 1'b0;

        vecs[0] = '{"v1234",       16'h1234, 1'b0, 4'b1111};
        vecs[1] = '{"v1234_bz",    16'h1234, 1'b1, 4'b1111};
        vecs[2] = '{"v0050_bz",    16'h0050, 1'b1, 4'b0011};
        vecs[3] = '{"v0000_bz",    16'h0000, 1'b1, 4'b0001};
        vecs[4] = '{"v0000",       16'h0000, 1'b0, 4'b1111};
        vecs[5] = '{"v0A00_bz",    16'h0A00, 1'b1, 4'b0111};
        vecs[6] = '{"vF00F_bz",    16'hF00F, 1'b1, 4'b1111};
        vecs[7] = '{"v0001",       16'h0001, 1'b0, 4'b1111};

        // Table: load, wait for the frame boundary, then check a full 24-clock frame.
        foreach (vecs[i]) begin
            do_reset();
            blank_ceros = vecs[i].blank;
            load(vecs[i].valor);
            check({vecs[i].name, "_busy_set"}, 16'(ocupado), 16'h1);
            run_to(23);
            check({vecs[i].name, "_busy_pre"}, 16'(ocupado), 16'h1);
            tick();
            check({vecs[i].name, "_busy_clr"}, 16'(ocupado), 16'h0);
            for (int n = 24; n < 48; n++) begin
                check({vecs[i].name, "_an"}, 16'(anodos), 16'(model_an(n, vecs[i].lit, 4, 6)));
                check({vecs[i].name, "_bits"}, 16'(bits), 16'(model_bits(n, vecs[i].valor, 6)));
                tick();
            end
        end
        blank_ceros = 1'b0;

        // Reset mid-scan discards a pending load; digit 0 then lit for 4 clocks.
        do_reset();
        load(16'h9999);
        run_to(9);
        check("pre_rst_an", 16'(anodos), 16'hD);
        do_reset();
        for (int n = 0; n < 5; n++) begin
            check("post_rst_an", 16'(anodos), 16'(model_an(n, 4'hF, 4, 6)));
            tick();
        end
        run_to(24);
        check("post_rst_bits", 16'(bits), 16'h0);
        check("post_rst_busy", 16'(ocupado), 16'h0);

        // Tear-free load during digit 1.
        do_reset();
        load(16'h1234);
        run_to(30);
        load(16'hABCD);
        check("tear_busy", 16'(ocupado), 16'h1);
        run_to(36);
        check("tear_d2_bits", 16'(bits), 16'h2);
        check("tear_d2_an", 16'(anodos), 16'hB);
        run_to(42);
        check("tear_d3_bits", 16'(bits), 16'h1);
        run_to(47);
        check("tear_busy_hold", 16'(ocupado), 16'h1);
        run_to(48);
        check("tear_new_d0", 16'(bits), 16'hD);
        check("tear_new_an0", 16'(anodos), 16'hE);
        check("tear_busy_clr", 16'(ocupado), 16'h0);
        run_to(54);
        check("tear_new_d1", 16'(bits), 16'hC);
        run_to(60);
        check("tear_new_d2", 16'(bits), 16'hB);
        run_to(66);
        check("tear_new_d3", 16'(bits), 16'hA);
        check("tear_new_an3", 16'(anodos), 16'h7);

        // Back-to-back loads: newest wins.
        do_reset();
        load(16'h1111);
        load(16'h2222);
        check("b2b_busy", 16'(ocupado), 16'h1);
        run_to(24);
        check("b2b_d0", 16'(bits), 16'h2);
        check("b2b_busy_clr", 16'(ocupado), 16'h0);
        run_to(42);
        check("b2b_d3", 16'(bits), 16'h2);

        // Load on the wrap clock: old shadow displayed, busy stays set.
        do_reset();
        load(16'h5555);
        run_to(23);
        load(16'h6666);
        check("wrap_bits", 16'(bits), 16'h5);
        check("wrap_busy", 16'(ocupado), 16'h1);
        run_to(48);
        check("wrap_next_bits", 16'(bits), 16'h6);
        check("wrap_next_busy", 16'(ocupado), 16'h0);

        // i_Blank_Ceros acts on the next clock, mid-frame.
        do_reset();
        load(16'h0050);
        run_to(42);
        check("bz_off_an", 16'(anodos), 16'h7);
        blank_ceros = 1'b1;
        tick();
        check("bz_on_an", 16'(anodos), 16'hF);
        blank_ceros = 1'b0;
        tick();
        check("bz_off2_an", 16'(anodos), 16'h7);

        // No-guard build: never all-inactive, a new digit every 4 clocks.
        do_reset();
        load(16'h1234);
        for (int n = 1; n < 40; n++) begin
            check("ng_an", 16'(anodos_ng), 16'(model_an(n, 4'hF, 4, 4)));
            if (n >= 16) check("ng_bits", 16'(bits_ng), 16'(model_bits(n, 16'h1234, 4)));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplexor_display.md
MULTIPLEXOR_DISPLAY -- requirements
Module: multiplexor_display

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000; length of each digit ON window, in clocks (>=1).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16; anode-off guard interval between digits, in clocks (0 = no guard).
REQ-003 SHALL have parameter AN_ACTIVE_LOW, default 1; 1 = anodes asserted low, 0 = asserted high.
REQ-004 SHALL have port i_Clk, input, 1 bit; the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_Reset, input, 1 bit; reset, asynchronous, active-high.
REQ-006 SHALL have port i_Valor, input, 16 bits; four BCD/hex nibbles, where [3:0] is digit 0 (least significant).
REQ-007 SHALL have port i_Cargar, input, 1 bit; single-cycle load strobe for i_Valor.
REQ-008 SHALL have port i_Blank_Ceros, input, 1 bit; enables leading-zero blanking.
REQ-009 SHALL have port o_Bits, output, 4 bits; nibble of the current digit, which feeds the 7-segment decoder's i_Bits.
REQ-010 SHALL have port o_Anodos, output, 4 bits; digit enables, with bit k driving digit k.
REQ-011 SHALL have port o_Ocupado, output, 1 bit; high while a loaded value waits for the frame boundary.

Function
REQ-012 SHALL implement a two-state FSM, ON and BLANK.
- In ON: the prescaler counts 0..CLK_DIV-1.
- At terminal count: go to BLANK, or skip BLANK if BLANK_CYCLES=0.
- In BLANK: count 0..BLANK_CYCLES-1, then go back to ON.
REQ-013 SHALL advance the digit index on every BLANK->ON transition (or ON->ON transition when BLANK_CYCLES=0), as 0->1->2->3->0.
REQ-014 SHALL clear the prescaler on every state transition, so one full scan period is CLK_DIV+BLANK_CYCLES clocks per digit.
REQ-015 SHALL drive o_Anodos during ON as one-hot on the current index (polarity per AN_ACTIVE_LOW), and during BLANK as all inactive.
REQ-016 SHALL drive o_Bits as the displayed-register nibble of the current index; o_Bits is not forced during BLANK.
REQ-017 SHALL, on a clock with i_Cargar=1, capture i_Valor into the shadow register and set o_Ocupado=1 on the next clock.
REQ-018 SHALL copy shadow to the displayed register and clear o_Ocupado on the clock where the index wraps 3->0, but only if o_Ocupado=1.
REQ-019 SHALL let the newest value win when i_Cargar repeats while o_Ocupado=1; o_Ocupado stays 1.
REQ-020 SHALL let the load win when i_Cargar=1 coincides with the wrap clock: shadow takes i_Valor, the displayed register takes the old shadow, and o_Ocupado stays 1.
REQ-021 SHALL, when i_Blank_Ceros=1, make digit k (k=1..3) inactive if it and all higher digits are zero in the displayed register; digit 0 is never blanked.
REQ-022 SHALL register all outputs, with no combinational path from any input to any output.
REQ-023 SHALL make i_Blank_Ceros take effect from the next clock and SHALL NOT synchronize it to frame boundaries.

Reset
REQ-024 SHALL, while i_Reset=1 (asynchronous), hold FSM=ON, prescaler=0, index=0, shadow=0, displayed=0, o_Ocupado=0.
REQ-025 SHALL, while i_Reset=1, hold o_Bits=4'h0 and o_Anodos = digit 0 active (4'b1110 when AN_ACTIVE_LOW=1).
REQ-026 SHALL discard any pending load when reset asserts mid-operation, and SHALL resume scanning from digit 0 on the first clock after deassertion.

Structure
REQ-027 SHALL place the FSM state encoding (ON/BLANK) and the NUM_DIGITS=4 constant in a shared package used by the display blocks.
REQ-028 SHALL be instantiated upstream of the 7-segment decoder, with o_Bits connected to the decoder's i_Bits.
REQ-029 SHALL factor the prescaler into one sub-module, contador_prescaler, with reset, clear and terminal-count outputs.

Verification (CLK_DIV=4, BLANK_CYCLES=2, AN_ACTIVE_LOW=1)
REQ-030 SHALL check reset: pulse i_Reset mid-scan -> o_Anodos=1110, o_Bits=0, o_Ocupado=0 immediately; digit 0 is on for 4 clocks after release.
REQ-031 SHALL check scan: load 16'h1234, wait one frame -> per digit, 4 clocks ON then 2 clocks of 1111; anodes 1110/1101/1011/0111 with o_Bits 4/3/2/1; period 24 clocks.
REQ-032 SHALL check tear-free load: load 16'hABCD during digit 1 -> o_Ocupado=1, o_Bits keeps old values for digits 2-3, then shows D,C,B,A from the next digit 0 with o_Ocupado=0.
REQ-033 SHALL check leading-zero blanking: i_Valor=16'h0050 with i_Blank_Ceros=1 -> digits 2 and 3 read 1111 during their ON windows; digit 0 shows 0 with anode active.
REQ-034 SHALL check all-zero blanking: i_Valor=16'h0000 with blanking on -> only digit 0 lights.
REQ-035 SHALL check collisions: back-to-back loads 16'h1111 then 16'h2222 -> 2222 is displayed. A load on the wrap clock -> the previous shadow is displayed and o_Ocupado stays 1.
REQ-036 SHALL check the no-guard case: BLANK_CYCLES=0 build -> anodes never all inactive; index advances every 4 clocks.
